// File: rtl/bin_clause_mover_pkg.sv
// Shared types and helpers for the clause-bin mover between BRAM and the clause array.
package bin_clause_mover_pkg;

  typedef enum logic {
    MODE_LOAD  = 1'b0,
    MODE_STORE = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_ISSUE = 3'd1,
    LD_DRAIN = 3'd2,
    ST_RD    = 3'd3,
    ST_WB    = 3'd4,
    DONE     = 3'd5
  } state_e;

  // A bin never holds more rows than the clause array, so oversized requests saturate.
  function automatic int unsigned clamp_n(input int unsigned n, input int unsigned max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/bin_clause_mover_if.sv
// Request, BRAM and clause-array signals of the mover; _i/_o names are from the mover's side.
interface bin_clause_mover_if
  import bin_clause_mover_pkg::*;
#(
  parameter int NUM_CLAUSES_A_BIN  = 8,
  parameter int NUM_VARS_A_BIN     = 8,
  parameter int WIDTH_BIN_ID       = 10,
  parameter int ADDR_WIDTH_CLAUSES = 9
);
  localparam int CW = 2 * NUM_VARS_A_BIN;
  localparam int NW = $clog2(NUM_CLAUSES_A_BIN) + 1;

  logic                          start_i;
  logic                          mode_i;
  logic [WIDTH_BIN_ID-1:0]       bin_id_i;
  logic [NW-1:0]                 n_clauses_i;
  logic                          busy_o;
  logic                          done_o;
  logic                          ram_en_o;
  logic                          ram_we_o;
  logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_o;
  logic [CW-1:0]                 ram_din_o;
  logic [CW-1:0]                 ram_dout_i;
  logic [NUM_CLAUSES_A_BIN-1:0]  wr_carray_o;
  logic [CW-1:0]                 clause_o;
  logic [NUM_CLAUSES_A_BIN-1:0]  rd_carray_o;
  logic [CW-1:0]                 clause_i;

  modport slave (
    input  start_i, mode_i, bin_id_i, n_clauses_i, ram_dout_i, clause_i,
    output busy_o, done_o, ram_en_o, ram_we_o, ram_addr_o, ram_din_o,
           wr_carray_o, clause_o, rd_carray_o
  );

  modport master (
    output start_i, mode_i, bin_id_i, n_clauses_i, ram_dout_i, clause_i,
    input  busy_o, done_o, ram_en_o, ram_we_o, ram_addr_o, ram_din_o,
           wr_carray_o, clause_o, rd_carray_o
  );

endinterface

// File: rtl/bin_clause_mover_rd_latency_pipe.sv
// Shift register of {valid, row index} that mirrors the BRAM read latency,
// so each read's data is paired with its destination row when it emerges.
module rd_latency_pipe #(
  parameter int LAT   = 1,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid_i,
  input  logic [IDX_W-1:0] push_idx_i,
  output logic             pop_valid_o,
  output logic [IDX_W-1:0] pop_idx_o,
  output logic             inflight_o
);

  logic [LAT-1:0]   valid_q;
  logic [IDX_W-1:0] idx_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
    end else begin
      valid_q[0] <= push_valid_i;
      idx_q[0]   <= push_idx_i;
      for (int i = LAT - 1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign pop_valid_o = valid_q[LAT-1];
  assign pop_idx_o   = idx_q[LAT-1];

  // Reads still travelling behind the output stage; the last stage drains this cycle.
  generate
    if (LAT > 1) begin : g_inflight
      assign inflight_o = |valid_q[LAT-2:0];
    end else begin : g_no_inflight
      assign inflight_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/bin_clause_mover.sv
// One-clause-per-cycle mover: LOAD copies a bin from BRAM into the clause array,
// STORE writes the clause array back to the bin in BRAM.
module bin_clause_mover
  import bin_clause_mover_pkg::*;
#(
  parameter int NUM_CLAUSES_A_BIN  = 8,
  parameter int NUM_VARS_A_BIN     = 8,
  parameter int WIDTH_BIN_ID       = 10,
  parameter int ADDR_WIDTH_CLAUSES = 9,
  parameter int RD_LATENCY         = 1
) (
  input logic                clk,
  input logic                rst,
  bin_clause_mover_if.slave  bus
);

  localparam int CNT_W  = $clog2(NUM_CLAUSES_A_BIN) + 1;
  localparam int ROW_W  = (NUM_CLAUSES_A_BIN > 1) ? $clog2(NUM_CLAUSES_A_BIN) : 1;
  localparam int PROD_W = WIDTH_BIN_ID + CNT_W;

  state_e                       state_q, state_d;
  logic [PROD_W-1:0]            base_q;
  logic [CNT_W-1:0]             n_q;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [CNT_W-1:0]             n_acc;
  logic                         ld_issue, st_rd, wb_active;
  logic [CNT_W-1:0]             addr_row;
  logic [PROD_W-1:0]            addr_full;
  logic                         pop_valid, inflight;
  logic [ROW_W-1:0]             pop_idx;
  logic [NUM_CLAUSES_A_BIN-1:0] wr_strobe, rd_strobe;

  assign n_acc = CNT_W'(clamp_n(32'(bus.n_clauses_i), NUM_CLAUSES_A_BIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.start_i) begin
        base_q <= PROD_W'(bus.bin_id_i) * PROD_W'(NUM_CLAUSES_A_BIN);
        n_q    <= n_acc;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_issue = 1'b0;
    st_rd    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start_i) begin
          if (n_acc == '0)                                state_d = DONE;
          else if (mode_e'(bus.mode_i) == MODE_STORE)     state_d = ST_RD;
          else                                            state_d = LD_ISSUE;
        end
      end
      LD_ISSUE: begin
        ld_issue = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == n_q - 1'b1) state_d = LD_DRAIN;
      end
      LD_DRAIN: begin
        if (!inflight) state_d = DONE;
      end
      ST_RD: begin
        st_rd = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == n_q - 1'b1) state_d = ST_WB;
      end
      ST_WB:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row c is read from the array in cycle c and written back one cycle later.
  assign wb_active = (st_rd && cnt_q != '0) || (state_q == ST_WB);
  assign addr_row  = wb_active ? cnt_q - 1'b1 : cnt_q;
  assign addr_full = base_q + PROD_W'(addr_row);

  rd_latency_pipe #(
    .LAT   (RD_LATENCY),
    .IDX_W (ROW_W)
  ) u_pipe (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (ld_issue),
    .push_idx_i   (cnt_q[ROW_W-1:0]),
    .pop_valid_o  (pop_valid),
    .pop_idx_o    (pop_idx),
    .inflight_o   (inflight)
  );

  generate
    for (genvar gi = 0; gi < NUM_CLAUSES_A_BIN; gi++) begin : g_strobe
      assign rd_strobe[gi] = st_rd && (cnt_q == CNT_W'(gi));
      assign wr_strobe[gi] = pop_valid && (pop_idx == ROW_W'(gi));
    end
  endgenerate

  assign bus.busy_o      = (state_q != IDLE);
  assign bus.done_o      = (state_q == DONE);
  assign bus.ram_en_o    = ld_issue | wb_active;
  assign bus.ram_we_o    = wb_active;
  assign bus.ram_addr_o  = (ld_issue | wb_active) ? ADDR_WIDTH_CLAUSES'(addr_full) : '0;
  assign bus.ram_din_o   = wb_active ? bus.clause_i : '0;
  assign bus.wr_carray_o = wr_strobe;
  assign bus.clause_o    = pop_valid ? bus.ram_dout_i : '0;
  assign bus.rd_carray_o = rd_strobe;

endmodule

// File: tb/tb_bin_clause_mover.sv
// Directed bench: two movers (read latency 1 and 3) share stimulus; each has its own BRAM and array model.
module tb_bin_clause_mover;

  localparam int NC = 8;
  localparam int NV = 8;
  localparam int WB = 10;
  localparam int AW = 9;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st = 1'b0;
  logic          md = 1'b0;
  logic [WB-1:0] bid = '0;
  logic [3:0]    ncl = '0;
  logic          sel = 1'b0;
  logic          mem_init = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  bin_clause_mover_if #(.NUM_CLAUSES_A_BIN(NC), .NUM_VARS_A_BIN(NV), .WIDTH_BIN_ID(WB),
                        .ADDR_WIDTH_CLAUSES(AW)) if1 ();
  bin_clause_mover_if #(.NUM_CLAUSES_A_BIN(NC), .NUM_VARS_A_BIN(NV), .WIDTH_BIN_ID(WB),
                        .ADDR_WIDTH_CLAUSES(AW)) if3 ();

  bin_clause_mover #(.NUM_CLAUSES_A_BIN(NC), .NUM_VARS_A_BIN(NV), .WIDTH_BIN_ID(WB),
                     .ADDR_WIDTH_CLAUSES(AW), .RD_LATENCY(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave));
  bin_clause_mover #(.NUM_CLAUSES_A_BIN(NC), .NUM_VARS_A_BIN(NV), .WIDTH_BIN_ID(WB),
                     .ADDR_WIDTH_CLAUSES(AW), .RD_LATENCY(3)) u_dut3 (
    .clk (clk), .rst (rst), .bus (if3.slave));

  assign if1.start_i = st;  assign if3.start_i = st;
  assign if1.mode_i = md;   assign if3.mode_i = md;
  assign if1.bin_id_i = bid; assign if3.bin_id_i = bid;
  assign if1.n_clauses_i = ncl; assign if3.n_clauses_i = ncl;

  // BRAM models: latency 1 and latency 3, preset to 16'hA500 + address.
  logic [CW-1:0] mem1 [512];
  logic [CW-1:0] mem3 [512];
  logic [CW-1:0] dout1 = '0;
  logic [CW-1:0] rdp3 [3];
  logic [CW-1:0] arr1 = '0;
  logic [CW-1:0] arr3 = '0;

  function automatic int oh_idx(input logic [NC-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < NC; i++) if (oh[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem1[i] <= 16'hA500 + 16'(i);
    end else if (if1.ram_en_o && if1.ram_we_o) begin
      mem1[if1.ram_addr_o] <= if1.ram_din_o;
    end
    if (if1.ram_en_o && !if1.ram_we_o) dout1 <= mem1[if1.ram_addr_o];
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem3[i] <= 16'hA500 + 16'(i);
    end else if (if3.ram_en_o && if3.ram_we_o) begin
      mem3[if3.ram_addr_o] <= if3.ram_din_o;
    end
    rdp3[0] <= mem3[if3.ram_addr_o];
    rdp3[1] <= rdp3[0];
    rdp3[2] <= rdp3[1];
  end

  // Clause-array models: row r holds 16'h3C00 + r, returned the cycle after its read strobe.
  always @(posedge clk) begin
    arr1 <= (if1.rd_carray_o != '0) ? 16'h3C00 + 16'(oh_idx(if1.rd_carray_o)) : '0;
    arr3 <= (if3.rd_carray_o != '0) ? 16'h3C00 + 16'(oh_idx(if3.rd_carray_o)) : '0;
  end

  assign if1.ram_dout_i = dout1;
  assign if3.ram_dout_i = rdp3[2];
  assign if1.clause_i   = arr1;
  assign if3.clause_i   = arr3;

  // {busy, done, en, we, addr, din, wr_carray, rd_carray, clause_o}
  logic [60:0] obs1, obs3, obs;
  assign obs1 = {if1.busy_o, if1.done_o, if1.ram_en_o, if1.ram_we_o, if1.ram_addr_o,
                 if1.ram_din_o, if1.wr_carray_o, if1.rd_carray_o, if1.clause_o};
  assign obs3 = {if3.busy_o, if3.done_o, if3.ram_en_o, if3.ram_we_o, if3.ram_addr_o,
                 if3.ram_din_o, if3.wr_carray_o, if3.rd_carray_o, if3.clause_o};
  assign obs  = sel ? obs3 : obs1;

  // Expected outputs k cycles after the accept cycle of a LOAD.
  function automatic logic [60:0] load_exp(int k, int base, int ne, int lat);
    int dk, r;
    logic en;
    logic [8:0] a;
    logic [7:0] wr;
    logic [15:0] cl;
    dk = (ne == 0) ? 1 : ne + lat + 1;
    r  = k - 1 - lat;
    en = (k <= ne);
    a  = en ? 9'((base + k - 1) % 512) : 9'h0;
    wr = (r >= 0 && r < ne) ? 8'(1 << r) : 8'h0;
    cl = (r >= 0 && r < ne) ? 16'hA500 + 16'((base + r) % 512) : 16'h0;
    return {(k <= dk), (k == dk), en, 1'b0, a, 16'h0, wr, 8'h0, cl};
  endfunction

  // Expected outputs k cycles after the accept cycle of a STORE.
  function automatic logic [60:0] store_exp(int k, int base, int ne);
    int dk;
    logic wb;
    logic [8:0] a;
    logic [15:0] din;
    logic [7:0] rd;
    dk  = (ne == 0) ? 1 : ne + 2;
    wb  = (k >= 2 && k <= ne + 1);
    a   = wb ? 9'((base + k - 2) % 512) : 9'h0;
    din = wb ? 16'h3C00 + 16'(k - 2) : 16'h0;
    rd  = (k <= ne) ? 8'(1 << (k - 1)) : 8'h0;
    return {(k <= dk), (k == dk), wb, wb, a, din, 8'h0, rd, 16'h0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic m, input int b, input int n);
    st  = 1'b1;
    md  = m;
    bid = WB'(b);
    ncl = 4'(n);
    cyc();
    st  = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) rst = 1'b0;
      vectors++;
      if (obs1 !== 61'h0 || obs3 !== 61'h0) begin
        miscompares++;
        $display("FAIL reset k=%0d got1=%h got3=%h exp=0", k, obs1, obs3);
      end
      cyc();
    end
    $display("reset: outputs idle");
  endtask

  // inject pulses start (STORE, n=4) mid-transfer and in the DONE cycle; both must be ignored.
  task automatic test_load(input int b, input int n, input int lat, input bit inject, input string tag);
    int ne, base, dk, dones;
    logic [60:0] e;
    sel   = (lat == 3);
    ne    = (n > NC) ? NC : n;
    base  = (b * NC) % 512;
    dk    = (ne == 0) ? 1 : ne + lat + 1;
    dones = 0;
    start_xfer(1'b0, b, n);
    for (int k = 1; k <= dk + 3; k++) begin
      e = load_exp(k, base, ne, lat);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL %s k=%0d got=%h exp=%h", tag, k, obs, e);
      end
      if (obs[59]) dones++;
      if (inject && (k == 3 || k == dk)) begin
        st = 1'b1; md = 1'b1; ncl = 4'd4;
      end else begin
        st = 1'b0;
      end
      cyc();
    end
    st = 1'b0;
    vectors++;
    if (dones !== 1) begin
      miscompares++;
      $display("FAIL %s_done_count got=%0d exp=1", tag, dones);
    end
    $display("load %s bin=%0d n=%0d lat=%0d done_pulses=%0d", tag, b, n, lat, dones);
  endtask

  task automatic test_store(input int b, input int n, input string tag);
    int ne, base, dk;
    logic [60:0] e;
    sel  = 1'b0;
    ne   = (n > NC) ? NC : n;
    base = (b * NC) % 512;
    dk   = (ne == 0) ? 1 : ne + 2;
    start_xfer(1'b1, b, n);
    for (int k = 1; k <= dk + 3; k++) begin
      e = store_exp(k, base, ne);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL %s k=%0d got=%h exp=%h", tag, k, obs, e);
      end
      cyc();
    end
    for (int r = 0; r < ne; r++) begin
      vectors++;
      if (mem1[(base + r) % 512] !== 16'h3C00 + 16'(r)) begin
        miscompares++;
        $display("FAIL %s_mem addr=%0d got=%h exp=%h", tag, (base + r) % 512,
                 mem1[(base + r) % 512], 16'h3C00 + 16'(r));
      end
    end
    $display("store %s bin=%0d n=%0d", tag, b, n);
  endtask

  task automatic test_reset_mid();
    logic [60:0] e;
    sel = 1'b0;
    start_xfer(1'b0, 2, 8);
    for (int k = 1; k <= 14; k++) begin
      e = (k >= 5) ? 61'h0 : load_exp(k, 16, 8, 1);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_mid k=%0d got=%h exp=%h", k, obs, e);
      end
      if (k == 4) rst = 1'b1;
      if (k == 5) rst = 1'b0;
      cyc();
    end
    $display("reset_mid: load abandoned at cycle 4");
  endtask

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    cyc();
    cyc();
    mem_init = 1'b0;
    test_reset();
    test_load(2, 8, 1, 1'b0, "load_b2");
    test_store(5, 8, "store_b5");
    test_load(1, 12, 3, 1'b0, "clamp_lat3");
    test_load(3, 0, 1, 1'b0, "zero_load");
    test_store(3, 0, "zero_store");
    test_load(70, 8, 1, 1'b0, "wrap_b70");
    test_load(2, 8, 1, 1'b1, "back_to_back");
    test_reset_mid();
    test_load(2, 8, 1, 1'b0, "after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin_clause_mover.md
Name: bin_clause_mover

Overview:
- Parametrised DMA-style mover between the clause-bins BRAM and the sat engine clause array.
- LOAD copies one bin's clauses from BRAM into the array. STORE copies the array back to BRAM after core solving.
- Successor to the fixed 8-clause load/update path in bin_manager.
- New capabilities: programmable clause count per bin, configurable BRAM read latency, and a fully pipelined one-clause-per-cycle transfer in both directions.

Parameters:
- NUM_CLAUSES_A_BIN, 8, clause-array rows; width of the one-hot strobes.
- NUM_VARS_A_BIN, 8, variables per bin; a clause word is 2*NUM_VARS_A_BIN bits.
- WIDTH_BIN_ID, 10, bin index width.
- ADDR_WIDTH_CLAUSES, 9, BRAM address width.
- RD_LATENCY, 1, BRAM read latency in cycles; legal values 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request; accepted only in IDLE.
- mode_i  in  1  0 = LOAD, 1 = STORE; sampled with start_i.
- bin_id_i  in  WIDTH_BIN_ID  bin to transfer; sampled with start_i.
- n_clauses_i  in  $clog2(NUM_CLAUSES_A_BIN)+1  clauses to move; sampled with start_i.
- busy_o  out  1  high from the accept cycle until done_o.
- done_o  out  1  one-cycle completion pulse.
- ram_en_o  out  1  BRAM enable.
- ram_we_o  out  1  BRAM write enable.
- ram_addr_o  out  ADDR_WIDTH_CLAUSES  BRAM address.
- ram_din_o  out  2*NUM_VARS_A_BIN  BRAM write data.
- ram_dout_i  in  2*NUM_VARS_A_BIN  BRAM read data.
- wr_carray_o  out  NUM_CLAUSES_A_BIN  one-hot row write strobe (LOAD).
- clause_o  out  2*NUM_VARS_A_BIN  clause data to the array.
- rd_carray_o  out  NUM_CLAUSES_A_BIN  one-hot row read strobe (STORE).
- clause_i  in  2*NUM_VARS_A_BIN  array data; valid the cycle after rd_carray_o.

Behaviour:
- Reset: state IDLE. All outputs 0, including busy_o and done_o. Counters and the delay line are cleared. Reset mid-transfer abandons the transfer immediately: no done_o, no further strobes or BRAM access.
- Accept: start_i in IDLE latches mode, bin_id and n = min(n_clauses_i, NUM_CLAUSES_A_BIN). busy_o rises on the next cycle. start_i while busy is ignored.
- Address: base = bin_id * NUM_CLAUSES_A_BIN, computed at full product width. Row k maps to address (base + k) truncated to ADDR_WIDTH_CLAUSES, i.e. modulo wrap.
- n == 0: go IDLE -> DONE. done_o pulses on the cycle after accept. No BRAM or array activity.
- LOAD
  - States: LD_ISSUE, LD_DRAIN, DONE.
  - LD_ISSUE cycles c = 0..n-1: ram_en_o = 1, ram_we_o = 0, ram_addr_o = base + c.
  - A valid/index delay line of depth RD_LATENCY tracks each read. When a read emerges: wr_carray_o = 1 << idx and clause_o = ram_dout_i, both combinational from ram_dout_i in that cycle.
  - After the last issue, LD_DRAIN waits until the delay line is empty, then DONE.
  - Last wr_carray_o falls in accept+n+RD_LATENCY. done_o follows one cycle later.
- STORE
  - States: ST_RD, ST_WB, DONE.
  - Cycle c = 0..n-1: rd_carray_o = 1 << c.
  - Cycle c+1: ram_en_o = ram_we_o = 1, ram_addr_o = base + c, ram_din_o = clause_i.
  - Reads and writebacks overlap, so throughput is one clause per cycle.
  - ST_WB covers the final writeback. done_o pulses the cycle after the last write.
- DONE: done_o = 1 for one cycle, busy_o drops, and the block returns to IDLE. A start_i in the DONE cycle is ignored.
- Outside active cycles: wr_carray_o and rd_carray_o are 0, and ram_en_o and ram_we_o are 0.
- ram_we_o is never asserted in LOAD.

Decomposition:
- Package bin_clause_mover_pkg holds:
  - mode enum: MODE_LOAD, MODE_STORE.
  - state enum: IDLE, LD_ISSUE, LD_DRAIN, ST_RD, ST_WB, DONE.
  - function clamp_n.
- Sub-module rd_latency_pipe: parametrised RD_LATENCY-deep shift register of {valid, row index}, with a synchronous-reset clear.

Test Plan:
- LOAD, bin 2, n = 8, RD_LATENCY = 1, BRAM preset with pattern 16'hA500+addr -> reads at addresses 16..23 on consecutive cycles; wr_carray_o walks 8'h01..8'h80 carrying 16'hA510..16'hA517; done_o pulses 10 cycles after accept.
- STORE, bin 5, n = 8, clause_i = 16'h3C00+row -> BRAM writes 16'h3C00..16'h3C07 at addresses 40..47, one per cycle; done_o pulses 10 cycles after accept; BRAM contents checked afterwards.
- LOAD, n_clauses_i = 12 (clamped to 8), RD_LATENCY = 3 -> exactly 8 wr_carray_o pulses; done_o pulses 12 cycles after accept.
- n_clauses_i = 0 in either mode -> done_o one cycle after accept; ram_en_o, wr_carray_o and rd_carray_o stay 0 throughout.
- Address wrap: bin 70, n = 8 (base 560 mod 512 = 48) -> addresses 48..55.
- Back-to-back and reset cases:
  - A second start_i while busy is ignored: exactly one done_o.
  - rst asserted during cycle 4 of a LOAD -> all outputs 0 the next cycle; no done_o.
  - A new start after reset runs the full LOAD normally.
